// File: rtl/max_in_ten.sv
// max_in_ten: two-stage pipelined signed arg-max over ten 8-bit score lanes.
// Reports the largest score and its lane index; ties resolve to the lowest lane.
// Ports:
//   iClk     - clock, rising edge
//   iRst     - asynchronous active-high reset
//   iValid   - data_in carries a vector this cycle
//   data_in  - packed lanes, lane i at data_in[W*i +: W]
//   data_max - registered maximum score (signed)
//   oIndex   - registered lane index of data_max (0-9)
//   oValid   - registered valid, two cycles after iValid
module max_in_ten #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 10
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    input  logic [W*N-1:0]   data_in,
    output logic [W-1:0]     data_max,
    output logic [3:0]       oIndex,
    output logic             oValid
);

    localparam int unsigned IW = 4;
    localparam int unsigned L1 = 5;
    localparam int unsigned NA = 3;

    typedef struct packed {
        logic [W-1:0]  val;
        logic [IW-1:0] idx;
    } cand_t;

    // Higher-index candidate wins only when strictly greater (lowest-index tie-break).
    function automatic cand_t pick(input cand_t lo, input cand_t hi);
        if ($signed(hi.val) > $signed(lo.val)) begin
            return hi;
        end
        return lo;
    endfunction

    cand_t lane_c [N];
    cand_t l1_c   [L1];
    cand_t l2_c   [NA];
    cand_t a_q    [NA];
    logic  a_valid_q;
    cand_t l3_c;
    cand_t l4_c;

    // Unpack lanes and tag each with its index.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            lane_c[i].val = data_in[W*i +: W];
            lane_c[i].idx = IW'(i);
        end
    end

    // Levels 1 and 2: pairwise tournament; lanes 8/9 winner bypasses level 2.
    always_comb begin
        for (int i = 0; i < int'(L1); i++) begin
            l1_c[i] = pick(lane_c[2*i], lane_c[2*i+1]);
        end
        l2_c[0] = pick(l1_c[0], l1_c[1]);
        l2_c[1] = pick(l1_c[2], l1_c[3]);
        l2_c[2] = l1_c[4];
    end

    // Stage A: three surviving candidates plus valid.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < int'(NA); i++) begin
                a_q[i] <= '0;
            end
            a_valid_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NA); i++) begin
                a_q[i] <= l2_c[i];
            end
            a_valid_q <= iValid;
        end
    end

    // Levels 3 and 4: final reduction; c2 always holds the highest lanes.
    always_comb begin
        l3_c = pick(a_q[0], a_q[1]);
        l4_c = pick(l3_c, a_q[2]);
    end

    // Stage B: drives the outputs.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            data_max <= '0;
            oIndex   <= '0;
            oValid   <= 1'b0;
        end else begin
            data_max <= l4_c.val;
            oIndex   <= l4_c.idx;
            oValid   <= a_valid_q;
        end
    end

endmodule

// File: tb/tb_max_in_ten.sv
// tb_max_in_ten: directed plus randomized check of max_in_ten against a linear-scan arg-max model.
module tb_max_in_ten;

    logic        iClk;
    logic        iRst;
    logic        iValid;
    logic [79:0] data_in;
    logic [7:0]  data_max;
    logic [3:0]  oIndex;
    logic        oValid;

    int unsigned n_vec;
    int unsigned n_err;

    typedef struct {
        logic       v;
        logic [7:0] m;
        logic [3:0] i;
        logic       full;
    } exp_t;

    exp_t hist [2];

    max_in_ten dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iValid   (iValid),
        .data_in  (data_in),
        .data_max (data_max),
        .oIndex   (oIndex),
        .oValid   (oValid)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference: scan lanes 0..9, keep first occurrence of the signed maximum.
    function automatic exp_t model(input logic [79:0] vec, input logic v);
        exp_t e;
        int best;
        int bi;
        int x;
        best = -129;
        bi   = 0;
        for (int k = 0; k < 10; k++) begin
            x = int'($signed(vec[8*k +: 8]));
            if (x > best) begin
                best = x;
                bi   = k;
            end
        end
        e.v    = v;
        e.m    = 8'(best);
        e.i    = 4'(bi);
        e.full = v;
        return e;
    endfunction

    function automatic exp_t reset_exp(input logic full);
        exp_t e;
        e.v    = 1'b0;
        e.m    = 8'h00;
        e.i    = 4'd0;
        e.full = full;
        return e;
    endfunction

    task automatic check_out(input string tag, input exp_t e);
        n_vec++;
        assert (oValid === e.v) else begin
            n_err++;
            $error("FAIL %s oValid observed=%0b expected=%0b", tag, oValid, e.v);
        end
        if (e.full) begin
            n_vec++;
            assert (data_max === e.m) else begin
                n_err++;
                $error("FAIL %s data_max observed=%h expected=%h", tag, data_max, e.m);
            end
            n_vec++;
            assert (oIndex === e.i) else begin
                n_err++;
                $error("FAIL %s oIndex observed=%0d expected=%0d", tag, oIndex, e.i);
            end
        end
    endtask

    // At a falling edge: check the vector applied two steps earlier, then drive the next one.
    task automatic step(input string tag, input logic [79:0] vec, input logic v);
        @(negedge iClk);
        check_out(tag, hist[1]);
        hist[1] = hist[0];
        hist[0] = model(vec, v);
        data_in = vec;
        iValid  = v;
    endtask

    function automatic logic [79:0] rand_vec(input int mode);
        logic [79:0] vec;
        for (int k = 0; k < 10; k++) begin
            if (mode == 0) begin
                vec[8*k +: 8] = 8'($urandom);
            end else begin
                vec[8*k +: 8] = 8'($urandom_range(0, 3)) - 8'd1;
            end
        end
        return vec;
    endfunction

    logic [79:0] v_all80;

    initial begin
        n_vec   = 0;
        n_err   = 0;
        iRst    = 1'b1;
        iValid  = 1'b0;
        data_in = '0;
        hist[0] = reset_exp(1'b1);
        hist[1] = reset_exp(1'b1);

        #1;
        check_out("reset_init", reset_exp(1'b1));
        @(negedge iClk);
        iRst = 1'b0;

        step("mixed_sign", 80'h00_55_EA_48_A8_E8_28_E8_2E_2A, 1'b1);
        step("tie_all10",  {10{8'h10}}, 1'b1);
        step("tie_3_7",    80'h00_00_7F_00_00_00_7F_00_00_00, 1'b1);
        step("ext_81",     {8'h81, {9{8'h80}}}, 1'b1);
        v_all80 = {10{8'h80}};
        step("ext_80",     v_all80, 1'b1);
        step("stream_l2",  80'h00_00_00_00_00_00_00_30_00_00, 1'b1);
        step("stream_l5",  80'h00_00_00_00_40_00_00_00_00_00, 1'b1);
        step("stream_l9",  80'h50_00_00_00_00_00_00_00_00_00, 1'b1);
        step("gap",        80'h00_00_00_00_00_00_00_00_7F_00, 1'b0);
        step("after_gap",  80'h00_00_00_00_00_00_00_00_7F_00, 1'b1);
        step("passthru",   {8'h01, {9{8'hF0}}}, 1'b1);
        step("flush0",     '0, 1'b0);
        step("flush1",     '0, 1'b0);

        // Explicit checks of the mixed-sign case independent of the model.
        step("mixed_again", 80'h00_55_EA_48_A8_E8_28_E8_2E_2A, 1'b1);
        step("hold0", '0, 1'b0);
        @(negedge iClk);
        n_vec++;
        assert (data_max === 8'h55 && oIndex === 4'd8 && oValid === 1'b1) else begin
            n_err++;
            $error("FAIL mixed_direct observed=%h/%0d/%0b expected=55/8/1", data_max, oIndex, oValid);
        end
        hist[1] = hist[0];
        hist[0] = model('0, 1'b0);
        iValid  = 1'b0;

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            step("rand", rand_vec(int'($urandom_range(0, 1))), ($urandom_range(0, 4) != 0));
        end

        // Mid-stream reset: outputs clear before any clock edge.
        step("pre_rst0", rand_vec(0), 1'b1);
        step("pre_rst1", rand_vec(0), 1'b1);
        @(posedge iClk);
        #2;
        iRst = 1'b1;
        #1;
        check_out("reset_async", reset_exp(1'b1));
        @(negedge iClk);
        check_out("reset_held", reset_exp(1'b1));
        iRst    = 1'b0;
        iValid  = 1'b0;
        hist[0] = reset_exp(1'b0);
        hist[1] = reset_exp(1'b0);

        for (int t = 0; t < 50; t++) begin
            step("rand_post", rand_vec(int'($urandom_range(0, 1))), ($urandom_range(0, 3) != 0));
        end
        step("end0", '0, 1'b0);
        step("end1", '0, 1'b0);
        step("end2", '0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/max_in_ten.md
Name: max_in_ten

Overview:
- Pipelined arg-max unit for the DNN digit classifier: picks the largest of ten signed 8-bit output-neuron scores and reports its value and lane index.
- Sits after the final fully-connected layer; oIndex is the recognised digit (0-9) driven to the display logic.
- Fixed two-cycle latency, fully pipelined: accepts one new vector every clock, no stall.

Parameters:
- W, 8, width of each score lane in bits (two's complement).
- N, 10, number of lanes (fixed; the index output is 4 bits).

Ports:
- iClk  input  1  system clock, rising-edge active.
- iRst  input  1  asynchronous, active-high reset.
- iValid  input  1  data_in holds a vector to evaluate this cycle.
- data_in  input  80  packed scores; lane i = data_in[8*i+7 : 8*i]; lane 0 in the LSBs, lane 9 in the MSBs.
- data_max  output  8  largest score of the accepted vector (signed).
- oIndex  output  4  lane number (0-9) of data_max.
- oValid  output  1  data_max/oIndex are valid this cycle.

Behaviour:
- Reset: one clock; asynchronous, active-high. While iRst=1, all pipeline registers clear immediately, without waiting for a clock edge: data_max=8'h00, oIndex=4'd0, oValid=0. In-flight vectors are discarded. The first capture happens on the first rising edge after iRst deasserts.
- Comparison: signed two's-complement, so 8'h7F is the largest value and 8'h80 the smallest.
- Tie-break: the lowest lane index wins. In every comparator, the higher-index candidate replaces the lower one only if it is strictly greater.
- Tournament tree:
  - Level 1: pairs (0,1), (2,3), (4,5), (6,7), (8,9) give 5 winners.
  - Level 2: (w01,w23) and (w45,w67); w89 passes through. Result is 3 candidates, each carrying an 8-bit value and a 4-bit index.
  - Pipeline register A captures these 3 candidates plus iValid on every rising edge.
  - Level 3: compare (c0,c1).
  - Level 4: compare (result, c2).
  - Pipeline register B captures value, index and valid on every rising edge; it drives data_max, oIndex and oValid.
- Latency: a vector present with iValid=1 at edge k appears at the outputs after edge k+1, with oValid=1 during the cycle after edge k+1.
- Throughput: one vector per clock. Back-to-back vectors emerge back-to-back, in order.
- Invalid input: when iValid=0, the datapath still registers. data_max/oIndex may change, but oValid=0 at the matching output cycle. Consumers must qualify with oValid.
- oIndex is always in the range 0-9. Values 10-15 never occur.
- No internal state beyond the two pipeline stages.
- Reset asserted mid-stream clears both stages. Outputs return to reset values asynchronously.

Test Plan:
- Reset: assert iRst with traffic running -> data_max=0x00, oIndex=0, oValid=0 immediately, before any clock edge.
- Mixed-sign vector, lanes 9..0 = 0x00, 0x55, 0xEA, 0x48, 0xA8, 0xE8, 0x28, 0xE8, 0x2E, 0x2A with iValid=1 -> two cycles later data_max=0x55, oIndex=8, oValid=1. This confirms signed compare; an unsigned compare would wrongly give 0xEA, index 7.
- All lanes equal 0x10 -> data_max=0x10, oIndex=0 (lowest-index tie-break). Then lanes 3 and 7 both 0x7F, others 0x00 -> oIndex=3.
- Extremes: all lanes 0x80 except lane 9 = 0x81 -> data_max=0x81, oIndex=9. All lanes 0x80 -> data_max=0x80, oIndex=0.
- Streaming: three vectors on consecutive cycles with maxima at lanes 2, 5, 9 (0x30, 0x40, 0x50) -> oIndex 2, 5, 9 on three consecutive cycles, oValid held high. Insert one iValid=0 gap -> a single-cycle oValid=0 bubble at the matching output position.
- Pass-through path: only lane 9 positive (0x01), others negative -> data_max=0x01, oIndex=9. This exercises the level-2 bypass and the level-4 compare.
